pulse_stretch_sched: RTL and testbench

Round-robin scheduler that shares one pulse-stretching output channel among N requesters. Each requester issues single-cycle trigger pulses; the block queues one pending request per requester, grants the channel in round-robin order, and drives a stretched pulse of programmable length with a guaranteed low gap between consecutive stretched pulses. It sits between the trigger sources and the downstream consumer of stretched pulses, which sees a single output and an owner tag.

---
 rtl/pulse_stretch_sched.sv | 144 ++++++++++++++
 tb/tb_pulse_stretch_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretch_sched.sv
// Round-robin sharing of one pulse-stretching output among N requesters.
// Each requester holds at most one pending request; pulses are separated by a forced low gap.
module pulse_stretch_sched #(
    parameter int N     = 4,
    parameter int CNT_W = 4,
    parameter int GAP   = 1,
    localparam int OW   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_pulse,
    input  logic [CNT_W-1:0] stretch_len,
    output logic             pulse_out,
    output logic [OW-1:0]    owner,
    output logic             busy,
    output logic [N-1:0]     pending,
    output logic [N-1:0]     drop_pulse
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STRETCH = 2'd1,
        GAP_S   = 2'd2
    } state_t;

    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gcnt_q, gcnt_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    rr_q, rr_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     drop_q, drop_d;
    logic             pulse_q, busy_q;
    logic [N-1:0]     grant_s;
    logic [OW-1:0]    winner_s;

    // First set bit at or above start, wrapping; scanning downward lets the nearest hit win.
    function automatic logic [OW-1:0] pick_winner(input logic [N-1:0] req,
                                                   input logic [OW-1:0] start);
        logic [OW-1:0] w;
        int            idx;
        w = start;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            idx = (idx >= N) ? idx - N : idx;
            if (req[idx]) begin
                w = OW'(idx);
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

    // Round-robin winner among queued requests.
    always_comb begin
        winner_s = pick_winner(pending_q, rr_q);
    end

    // Scheduler FSM next state, grant and stretch/gap counters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        grant_s = '0;
        case (state_q)
            IDLE: begin
                if (pending_q != '0) begin
                    grant_s[winner_s] = 1'b1;
                    owner_d = winner_s;
                    rr_d    = (winner_s == OW'(N - 1)) ? '0 : winner_s + 1'b1;
                    cnt_d   = (stretch_len == '0) ? '0 : stretch_len - 1'b1;
                    state_d = STRETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            STRETCH: begin
                if (cnt_q == '0) begin
                    if (GAP > 0) begin
                        state_d = GAP_S;
                        gcnt_d  = GAP_LAST;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP_S: begin
                if (gcnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A request landing on its own grant edge is re-queued rather than dropped.
    always_comb begin
        pending_d = (pending_q & ~grant_s) | req_pulse;
        drop_d    = req_pulse & pending_q & ~grant_s;
    end

    // State and registered outputs; pulse/busy are derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gcnt_q    <= 4'd0;
            owner_q   <= '0;
            rr_q      <= '0;
            pending_q <= '0;
            drop_q    <= '0;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gcnt_q    <= gcnt_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
            pulse_q   <= (state_d == STRETCH);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign pulse_out  = pulse_q;
    assign owner      = owner_q;
    assign busy       = busy_q;
    assign pending    = pending_q;
    assign drop_pulse = drop_q;

endmodule

// File: tb/tb_pulse_stretch_sched.sv
// Self-checking bench for pulse_stretch_sched: vector table, corner sequences, random vs. model.
module tb_pulse_stretch_sched;

    localparam int N     = 4;
    localparam int CNT_W = 4;
    localparam int GAP   = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_pulse;
    logic [CNT_W-1:0] stretch_len;
    logic             pulse_out;
    logic [1:0]       owner;
    logic             busy;
    logic [N-1:0]     pending;
    logic [N-1:0]     drop_pulse;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining high / low cycles of the shared channel.
    logic [N-1:0] m_pend, m_drop;
    int           m_high, m_low, m_owner, m_rr;

    typedef struct {
        logic       r;
        logic [3:0] rq;
        logic [3:0] ln;
        logic       e_pulse;
        logic [1:0] e_owner;
        logic       e_busy;
        logic [3:0] e_pend;
        logic [3:0] e_drop;
    } vec_t;
    vec_t vq[$];

    pulse_stretch_sched #(.N(N), .CNT_W(CNT_W), .GAP(GAP)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_pulse   (req_pulse),
        .stretch_len (stretch_len),
        .pulse_out   (pulse_out),
        .owner       (owner),
        .busy        (busy),
        .pending     (pending),
        .drop_pulse  (drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] rq, input logic [3:0] ln);
        logic [N-1:0] grant;
        int           w;
        bit           found;
        grant = '0;
        if (r) begin
            m_pend = '0; m_drop = '0; m_high = 0; m_low = 0; m_owner = 0; m_rr = 0;
        end else begin
            if (m_high == 0 && m_low == 0 && m_pend != '0) begin
                found = 0; w = 0;
                for (int k = 0; k < N; k++) begin
                    if (!found && m_pend[(m_rr + k) % N]) begin
                        w = (m_rr + k) % N;
                        found = 1;
                    end
                end
                grant[w] = 1'b1;
                m_owner  = w;
                m_rr     = (w + 1) % N;
                m_high   = (ln == 4'd0) ? 1 : int'(ln);
            end else if (m_high > 0) begin
                m_high--;
                if (m_high == 0) m_low = GAP;
            end else if (m_low > 0) begin
                m_low--;
            end
            m_drop = rq & m_pend & ~grant;
            m_pend = (m_pend & ~grant) | rq;
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic apply(input logic r, input logic [3:0] rq, input logic [3:0] ln);
        rst = r; req_pulse = rq; stretch_len = ln;
        @(posedge clk);
        model_step(r, rq, ln);
        @(negedge clk);
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] ln);
        apply(r, rq, ln);
        chk("model_pulse",   32'(pulse_out),  32'(m_high > 0));
        chk("model_owner",   32'(owner),      32'(m_owner));
        chk("model_busy",    32'(busy),       32'(m_high > 0 || m_low > 0));
        chk("model_pending", 32'(pending),    32'(m_pend));
        chk("model_drop",    32'(drop_pulse), 32'(m_drop));
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic p, input logic [1:0] o,
                       input logic b, input logic [3:0] pd, input logic [3:0] dr);
        vec_t v;
        v = '{r, rq, 4'd3, p, o, b, pd, dr};
        vq.push_back(v);
    endtask

    initial begin
        int cnt, last_owner, drops0, drops2;
        logic prev_pulse;
        rst = 1'b1; req_pulse = '0; stretch_len = '0;
        m_pend = '0; m_drop = '0; m_high = 0; m_low = 0; m_owner = 0; m_rr = 0;

        // Single request, then 1011 round-robin, then grant-edge collision and a drop.
        add(1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000);
        add(1'b0, 4'b0010, 1'b0, 2'd0, 1'b0, 4'b0010, 4'b0000);
        add(1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b0000, 4'b0000);
        add(1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b0000, 4'b0000);
        add(1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b0000, 4'b0000);
        add(1'b0, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b0000, 4'b0000);
        add(1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 4'b0000, 4'b0000);
        add(1'b1, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000);
        add(1'b0, 4'b1011, 1'b0, 2'd0, 1'b0, 4'b1011, 4'b0000);
        add(1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b1010, 4'b0000);
        add(1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b1010, 4'b0000);
        add(1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b1010, 4'b0000);
        add(1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b1010, 4'b0000);
        add(1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 4'b1010, 4'b0000);
        add(1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b1000, 4'b0000);
        add(1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b1000, 4'b0000);
        add(1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 4'b1000, 4'b0000);
        add(1'b0, 4'b0000, 1'b0, 2'd1, 1'b1, 4'b1000, 4'b0000);
        add(1'b0, 4'b0000, 1'b0, 2'd1, 1'b0, 4'b1000, 4'b0000);
        add(1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 4'b0000, 4'b0000);
        add(1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 4'b0000, 4'b0000);
        add(1'b0, 4'b0000, 1'b1, 2'd3, 1'b1, 4'b0000, 4'b0000);
        add(1'b0, 4'b0000, 1'b0, 2'd3, 1'b1, 4'b0000, 4'b0000);
        add(1'b0, 4'b0000, 1'b0, 2'd3, 1'b0, 4'b0000, 4'b0000);
        add(1'b0, 4'b0001, 1'b0, 2'd3, 1'b0, 4'b0001, 4'b0000);
        add(1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0000);
        add(1'b0, 4'b0001, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0001);
        add(1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 4'b0001, 4'b0000);

        @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i].r, vq[i].rq, vq[i].ln);
            chk($sformatf("vec%0d_pulse", i), 32'(pulse_out),  32'(vq[i].e_pulse));
            chk($sformatf("vec%0d_owner", i), 32'(owner),      32'(vq[i].e_owner));
            chk($sformatf("vec%0d_busy", i),  32'(busy),       32'(vq[i].e_busy));
            chk($sformatf("vec%0d_pend", i),  32'(pending),    32'(vq[i].e_pend));
            chk($sformatf("vec%0d_drop", i),  32'(drop_pulse), 32'(vq[i].e_drop));
        end

        // Requester 2 re-requests on its own grant edge; it is served again after requester 0.
        step(1'b1, 4'b0000, 4'd3);
        step(1'b0, 4'b0100, 4'd3);
        step(1'b0, 4'b0101, 4'd3);
        chk("coll_owner", 32'(owner), 32'd2);
        chk("coll_pend",  32'(pending), 32'h5);
        chk("coll_drop",  32'(drop_pulse), 32'h0);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 4'd3);
        chk("coll_next0", 32'({pulse_out, owner}), 32'({1'b1, 2'd0}));
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 4'd3);
        chk("coll_next2", 32'({pulse_out, owner}), 32'({1'b1, 2'd2}));
        for (int i = 0; i < 6; i++) step(1'b0, 4'b0000, 4'd3);

        // Pulse length sampled at the grant edge only.
        step(1'b1, 4'b0000, 4'd0);
        step(1'b0, 4'b0001, 4'd7);
        step(1'b0, 4'b0000, 4'd15);
        cnt = pulse_out ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'b0000, 4'($urandom_range(0, 15)));
            if (pulse_out) cnt++;
        end
        chk("len15_cycles", 32'(cnt), 32'd15);
        step(1'b0, 4'b0001, 4'd9);
        step(1'b0, 4'b0000, 4'd0);
        cnt = pulse_out ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'b0000, 4'($urandom_range(0, 15)));
            if (pulse_out) cnt++;
        end
        chk("len0_cycles", 32'(cnt), 32'd1);

        // Reset in the 2nd cycle of a 5-cycle stretch with requester 2 queued.
        step(1'b1, 4'b0000, 4'd5);
        step(1'b0, 4'b0001, 4'd5);
        step(1'b0, 4'b0000, 4'd5);
        step(1'b0, 4'b0100, 4'd5);
        chk("rst_pre_pend", 32'(pending), 32'h4);
        step(1'b1, 4'b0000, 4'd5);
        chk("rst_outputs", 32'({pulse_out, owner, busy, pending, drop_pulse}), 32'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'b0000, 4'd5);
            if (pulse_out || pending != 4'b0000) cnt++;
        end
        chk("rst_quiet", 32'(cnt), 32'd0);

        // Requesters 0 and 2 held high: owners alternate and drops appear.
        step(1'b1, 4'b0000, 4'd2);
        last_owner = -1; drops0 = 0; drops2 = 0; prev_pulse = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 4'b0101, 4'd2);
            if (pulse_out && !prev_pulse) begin
                if (last_owner >= 0) chk("alt_owner_changes", 32'(owner != 2'(last_owner)), 32'd1);
                last_owner = int'(owner);
            end
            if (drop_pulse[0]) drops0++;
            if (drop_pulse[2]) drops2++;
            prev_pulse = pulse_out;
        end
        chk("alt_drop0_seen", 32'(drops0 > 0), 32'd1);
        chk("alt_drop2_seen", 32'(drops2 > 0), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 63) == 0), 4'($urandom) & 4'($urandom), 4'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
